// File: rtl/dmem_store_responder.sv
// Word RAM on the core's load/store port plus a completion checker that watches
// stores to the result address and raises sticky done/pass flags.
module dmem_store_responder #(
    parameter int          DEPTH          = 64,
    parameter logic [31:0] PASS_ADDR      = 32'd100,
    parameter logic [31:0] PASS_DATA      = 32'd25,
    parameter logic [31:0] SCRATCH_ADDR   = 32'd96,
    parameter bit          STRICT         = 1'b1,
    parameter int          TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        done,
    output logic        pass,
    output logic [31:0] fail_addr,
    output logic [15:0] store_count
);

    localparam int               IDX_W      = $clog2(DEPTH);
    localparam int               CNT_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [31:0]      MEM_BYTES  = 32'(DEPTH * 4);
    localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {RUN, PASSED, FAILED, TIMED_OUT} stateT;

    stateT            state;
    logic [31:0]      mem [DEPTH];
    logic [CNT_W-1:0] cycleCount;
    logic [IDX_W-1:0] wordIdx;
    logic             inRange;
    logic             aligned;
    logic             running;
    logic             passStore;
    logic             failStore;
    logic             timeoutHit;
    logic             memWrite;

    assign wordIdx    = DataAdr[IDX_W+1:2];
    assign inRange    = DataAdr < MEM_BYTES;
    assign aligned    = DataAdr[1:0] == 2'b00;
    assign running    = state == RUN;
    assign timeoutHit = cycleCount == LAST_CYCLE;

    // A result-address store never counts as a strict-mode violation; its data decides.
    assign passStore = MemWrite && DataAdr == PASS_ADDR && WriteData == PASS_DATA;
    assign failStore = MemWrite &&
                       ((DataAdr == PASS_ADDR && WriteData != PASS_DATA) ||
                        !aligned ||
                        (STRICT && DataAdr != SCRATCH_ADDR && DataAdr != PASS_ADDR));

    // Only stores that survive the checks land in RAM; a terminal state freezes it.
    assign memWrite = running && MemWrite && aligned && inRange && !failStore;

    // Old word is returned during a same-word write; the new value shows next cycle.
    assign ReadData = inRange ? mem[wordIdx] : 32'h0;

    // NOTE: RAM is deliberately left out of reset so its contents survive for post-mortem
    // and it maps onto block RAM; sequential state always uses non-blocking assignments.
    always_ff @(posedge clk) begin
        if (memWrite) mem[wordIdx] <= WriteData;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail_addr   <= 32'h0;
            store_count <= 16'h0;
            cycleCount  <= '0;
        end else if (running) begin
            cycleCount <= cycleCount + 1'b1;
            if (memWrite && store_count != 16'hFFFF) store_count <= store_count + 16'd1;
            if (passStore) begin
                state <= PASSED;
                done  <= 1'b1;
                pass  <= 1'b1;
            end else if (failStore) begin
                state     <= FAILED;
                done      <= 1'b1;
                fail_addr <= DataAdr;
            end else if (timeoutHit) begin
                state <= TIMED_OUT;
                done  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_store_responder.sv
// Bench for dmem_store_responder: directed vectors, multi-cycle corner sequences and
// randomized traffic compared against a rule-level model of two configurations.
module tb_dmem_store_responder;

    logic        clk = 1'b0;
    logic        reset, MemWrite;
    logic [31:0] DataAdr, WriteData;

    logic [31:0] rdS, rdL, rdT;
    logic        doneS, doneL, doneT, passS, passL, passT;
    logic [31:0] faS, faL, faT;
    logic [15:0] cntS, cntL, cntT;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_store_responder #(.STRICT(1'b1), .TIMEOUT_CYCLES(1000)) u_strict (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
        .WriteData(WriteData), .ReadData(rdS), .done(doneS), .pass(passS),
        .fail_addr(faS), .store_count(cntS));

    dmem_store_responder #(.STRICT(1'b0), .TIMEOUT_CYCLES(1000)) u_lax (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
        .WriteData(WriteData), .ReadData(rdL), .done(doneL), .pass(passL),
        .fail_addr(faL), .store_count(cntL));

    dmem_store_responder #(.STRICT(1'b1), .TIMEOUT_CYCLES(20)) u_short (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
        .WriteData(WriteData), .ReadData(rdT), .done(doneT), .pass(passT),
        .fail_addr(faT), .store_count(cntT));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge; combinational outputs are valid on return.
    task automatic drive(input bit r, input bit we, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        reset = r; MemWrite = we; DataAdr = a; WriteData = d;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit          rst;
        bit          we;
        logic [31:0] adr;
        logic [31:0] wd;
        bit          rdChk;
        logic [31:0] rd;
        bit          done;
        bit          pass;
        logic [31:0] fa;
        logic [15:0] cnt;
    } vecT;

    vecT vecs[$];

    function automatic vecT mk(bit rst, bit we, logic [31:0] adr, logic [31:0] wd, bit rdChk,
                               logic [31:0] rd, bit dn, bit ps, logic [31:0] fa, logic [15:0] cnt);
        vecT v;
        v.rst = rst; v.we = we; v.adr = adr; v.wd = wd; v.rdChk = rdChk; v.rd = rd;
        v.done = dn; v.pass = ps; v.fa = fa; v.cnt = cnt;
        return v;
    endfunction

    // Rule-level model: index 0 is the strict configuration, index 1 the lax one.
    logic [31:0] mMem   [2][64];
    bit          mKnown [2][64];
    bit          mDone  [2];
    bit          mPass  [2];
    logic [31:0] mFa    [2];
    int          mCnt   [2];
    int          mCyc   [2];

    function automatic void mReset();
        for (int m = 0; m < 2; m++) begin
            mDone[m] = 0; mPass[m] = 0; mFa[m] = 0; mCnt[m] = 0; mCyc[m] = 0;
        end
    endfunction

    function automatic void mStep(bit we, logic [31:0] a, logic [31:0] d);
        bit bad;
        for (int m = 0; m < 2; m++) begin
            if (!mDone[m]) begin
                bad = 0;
                if (we && a == 100) begin
                    if (d == 25) begin mDone[m] = 1; mPass[m] = 1; end
                    else bad = 1;
                end else if (we && a % 4 != 0) bad = 1;
                else if (we && m == 0 && a != 96) bad = 1;
                if (bad) begin
                    mDone[m] = 1;
                    mFa[m]   = a;
                end else begin
                    if (we && a % 4 == 0 && a < 256) begin
                        mMem[m][a / 4]   = d;
                        mKnown[m][a / 4] = 1;
                        if (mCnt[m] < 65535) mCnt[m]++;
                    end
                    if (!mDone[m] && mCyc[m] == 999) mDone[m] = 1;
                end
                mCyc[m]++;
            end
        end
    endfunction

    task automatic checkRead(input int m, input logic [31:0] act, input logic [31:0] a);
        if (a >= 256) check($sformatf("rand rd%0d oor", m), act, 32'h0);
        else if (mKnown[m][a / 4]) check($sformatf("rand rd%0d @%0d", m, a), act, mMem[m][a / 4]);
    endtask

    initial begin
        bit          we;
        logic [31:0] a, d;
        int          sel;

        reset = 1'b1; MemWrite = 1'b0; DataAdr = 32'h0; WriteData = 32'h0;
        for (int w = 0; w < 64; w++) begin
            mKnown[0][w] = 0; mKnown[1][w] = 0;
        end

        //          rst we adr  wd  rdChk rd  done pass fa   cnt
        vecs.push_back(mk(1, 0,   0,  0, 0,  0, 0, 0,   0, 0));
        vecs.push_back(mk(1, 0,   0,  0, 0,  0, 0, 0,   0, 0));
        vecs.push_back(mk(0, 1,  96,  7, 0,  0, 0, 0,   0, 1));
        vecs.push_back(mk(0, 1, 100, 25, 0,  0, 1, 1,   0, 2));
        vecs.push_back(mk(0, 0,  96,  0, 1,  7, 1, 1,   0, 2));
        vecs.push_back(mk(1, 0,   0,  0, 0,  0, 0, 0,   0, 0));
        vecs.push_back(mk(0, 0,  96,  0, 1,  7, 0, 0,   0, 0));
        vecs.push_back(mk(0, 1, 100, 24, 1, 25, 1, 0, 100, 0));
        vecs.push_back(mk(0, 1,  96,  9, 1,  7, 1, 0, 100, 0));
        vecs.push_back(mk(0, 0,  96,  0, 1,  7, 1, 0, 100, 0));
        vecs.push_back(mk(0, 0, 300,  0, 1,  0, 1, 0, 100, 0));
        vecs.push_back(mk(1, 0,   0,  0, 0,  0, 0, 0,   0, 0));
        vecs.push_back(mk(0, 1,  44,  3, 0,  0, 1, 0,  44, 0));
        vecs.push_back(mk(0, 0,  96,  0, 1,  7, 1, 0,  44, 0));
        vecs.push_back(mk(1, 0,   0,  0, 0,  0, 0, 0,   0, 0));
        vecs.push_back(mk(0, 1,  98,  1, 1,  7, 1, 0,  98, 0));
        vecs.push_back(mk(0, 0,  96,  0, 1,  7, 1, 0,  98, 0));
        vecs.push_back(mk(1, 0,   0,  0, 0,  0, 0, 0,   0, 0));
        vecs.push_back(mk(0, 1,  96, 11, 1,  7, 0, 0,   0, 1));
        vecs.push_back(mk(0, 0,  96,  0, 1, 11, 0, 0,   0, 1));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].we, vecs[i].adr, vecs[i].wd);
            if (vecs[i].rdChk) check($sformatf("vec%0d ReadData", i), rdS, vecs[i].rd);
            tick();
            check($sformatf("vec%0d done", i), doneS, vecs[i].done);
            check($sformatf("vec%0d pass", i), passS, vecs[i].pass);
            check($sformatf("vec%0d fail_addr", i), faS, vecs[i].fa);
            check($sformatf("vec%0d store_count", i), cntS, vecs[i].cnt);
        end

        // Lax configuration: foreign and out-of-range stores are tolerated.
        drive(1, 0, 0, 0); tick();
        drive(1, 0, 0, 0); tick();
        drive(0, 1, 44, 3); tick();
        check("lax 44 done", doneL, 0);
        check("lax 44 count", cntL, 1);
        drive(0, 0, 44, 0);
        check("lax load 44", rdL, 3);
        tick();
        drive(0, 1, 256, 5);
        check("lax rd oor", rdL, 0);
        tick();
        check("lax oor done", doneL, 0);
        check("lax oor count", cntL, 1);
        drive(0, 1, 252, 32'hDEADBEEF); tick();
        check("lax 252 count", cntL, 2);
        drive(0, 0, 252, 0);
        check("lax load 252", rdL, 32'hDEADBEEF);
        tick();
        drive(0, 1, 100, 24); tick();
        check("lax bad pass done", doneL, 1);
        check("lax bad pass fa", faL, 100);
        check("lax bad pass count", cntL, 2);
        drive(0, 0, 100, 0);
        check("lax pass word kept", rdL, 25);
        tick();

        // Timeout at exactly 20 cycles, then a result store on the timeout edge wins.
        drive(1, 0, 0, 0); tick();
        drive(1, 0, 0, 0); tick();
        for (int k = 1; k <= 21; k++) begin
            drive(0, 0, 0, 0); tick();
            check($sformatf("timeout done k=%0d", k), doneT, k >= 20);
            check($sformatf("timeout pass k=%0d", k), passT, 0);
        end
        drive(1, 0, 0, 0); tick();
        for (int k = 1; k <= 20; k++) begin
            drive(0, k == 20, 100, 25); tick();
            check($sformatf("late pass done k=%0d", k), doneT, k == 20);
            check($sformatf("late pass pass k=%0d", k), passT, k == 20);
        end

        // Randomized traffic against the model, several episodes separated by reset.
        for (int ep = 0; ep < 4; ep++) begin
            drive(1, 0, 0, 0); tick();
            drive(1, 0, 0, 0); tick();
            mReset();
            for (int c = 0; c < 200; c++) begin
                sel = $urandom_range(99);
                d   = $urandom;
                we  = 1'b1;
                if (sel < 60) begin
                    a = 32'($urandom_range(63)) * 4;
                    if (a == 100) a = 104;
                end else if (sel < 75) a = 96;
                else if (sel < 90) a = 256 + 32'($urandom_range(200)) * 4;
                else if (sel == 90) begin a = 100; d = 25; end
                else if (sel == 91) begin a = 100; d = 32'($urandom_range(24)); end
                else if (sel == 92) a = 32'($urandom_range(255)) | 32'h1;
                else begin we = 1'b0; a = 32'($urandom_range(300)); end
                if (sel < 60 && $urandom_range(3) == 0) we = 1'b0;
                drive(0, we, a, d);
                checkRead(0, rdS, a);
                checkRead(1, rdL, a);
                mStep(we, a, d);
                tick();
                check("rand strict done", doneS, mDone[0]);
                check("rand strict pass", passS, mPass[0]);
                check("rand strict fa", faS, mFa[0]);
                check("rand strict count", cntS, 32'(mCnt[0]));
                check("rand lax done", doneL, mDone[1]);
                check("rand lax pass", passL, mPass[1]);
                check("rand lax fa", faL, mFa[1]);
                check("rand lax count", cntL, 32'(mCnt[1]));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_store_responder.md
Name: dmem_store_responder

Overview:
- Data-memory responder on the single-cycle core's store/load port (MemWrite, DataAdr, WriteData in; ReadData out).
- Provides word RAM for loads/stores plus a synthesizable completion checker.
- The checker watches stores to the result address and drives sticky done/pass flags, so FPGA builds can report test outcome without a simulator.
- Sits beside top's datapath in place of the plain data memory.

Parameters:
- DEPTH, 64, number of 32-bit RAM words (byte range 0 .. DEPTH*4-1).
- PASS_ADDR, 100, byte address whose store ends the test.
- PASS_DATA, 25, value at PASS_ADDR that means success.
- SCRATCH_ADDR, 96, byte address of the only other store allowed while STRICT=1.
- STRICT, 1, 1: any store to another address fails the test; 0: any in-range aligned store allowed.
- TIMEOUT_CYCLES, 1000, cycles after reset release before the checker declares timeout.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- MemWrite  input  1  store strobe from core.
- DataAdr  input  32  byte address for load/store.
- WriteData  input  32  store data.
- ReadData  output  32  load data (combinational).
- done  output  1  test finished (PASS, FAIL or TIMEOUT).
- pass  output  1  test finished successfully.
- fail_addr  output  32  DataAdr of the store that caused FAIL.
- store_count  output  16  accepted stores since reset, saturating.

Behaviour:
- Reset values (sync, active-high): done=0, pass=0, fail_addr=0, store_count=0, cycle counter=0, FSM=RUN.
- RAM contents are not cleared by reset.
- Reset asserted mid-test or after a terminal state returns FSM to RUN on the next edge.
- Word index = DataAdr[log2(DEPTH)+1:2].
- "In-range" means DataAdr < DEPTH*4. "Aligned" means DataAdr[1:0]==0.
- RAM write at rising edge when all hold: MemWrite=1, aligned, in-range, FSM=RUN.
- Once FSM leaves RUN, all further writes are suppressed, freezing memory for post-mortem.
- ReadData is combinational: mem[index] when in-range, else 32'h0. Alignment bits are ignored on reads.
- Read-during-write to the same word returns the old word; the new value is visible next cycle.
- FSM states: RUN, PASS, FAIL, TIMEOUT. PASS, FAIL and TIMEOUT are sticky until reset.
- Transitions from RUN are evaluated every rising edge with reset=0, in this priority order:
  1. MemWrite & DataAdr==PASS_ADDR & WriteData==PASS_DATA -> PASS.
  2. MemWrite & DataAdr==PASS_ADDR & WriteData!=PASS_DATA -> FAIL.
  3. MemWrite & misaligned -> FAIL.
  4. MemWrite & STRICT & DataAdr!=SCRATCH_ADDR -> FAIL.
  5. cycle counter == TIMEOUT_CYCLES-1 -> TIMEOUT.
- A PASS_ADDR store on the timeout cycle takes the store's outcome (priority 1/2 beats 5).
- On entry to FAIL, fail_addr captures DataAdr. It is 0 for any other terminal state.
- done=1 in PASS, FAIL or TIMEOUT. pass=1 only in PASS. Both are registered, so they assert the cycle after the deciding edge.
- Stores that pass the checks are written to RAM in the same edge, including the final PASS_ADDR store.
- store_count increments on each RAM write and saturates at 16'hFFFF.
- Cycle counter increments every cycle in RUN and holds in terminal states. It is wide enough for TIMEOUT_CYCLES.
- With STRICT=0, an out-of-range aligned store is dropped silently: no write, no FAIL, no count.

Test Plan:
- Reset 2 cycles; store 96<-7, then 100<-25 -> store_count=2; done=1 and pass=1 the cycle after the second store; load 96 returns 7.
- Store 100<-24 -> done=1, pass=0, fail_addr=100; a later store 96<-9 is ignored and load 96 is unchanged.
- STRICT=1, store 44<-3 -> FAIL, fail_addr=44. Repeat with STRICT=0 -> stays RUN, load 44 returns 3.
- Store 98<-1 (misaligned) -> FAIL, fail_addr=98, no RAM change.
- No stores, TIMEOUT_CYCLES=20 -> done=1 exactly 20 cycles after reset release, pass=0. A PASS_ADDR store on cycle 19 yields PASS instead.
- Reach PASS, reassert reset for 1 cycle -> done=0, pass=0, store_count=0; RAM word 96 still holds its earlier value.
